bf16_drain_arbiter: RTL and testbench

Shares one `int20_to_bf16` converter among `NUM_LANES` accumulator lanes of the systolic array during result drain. It uses round-robin arbitration and a two-stage register pipeline, so throughput is one conversion per cycle. Lane requests use valid/ready handshakes. The result stream, bf16 word plus source-lane tag, goes downstream (output FIFO / host readout) over a valid/ready handshake with full backpressure.

---
 rtl/bf16_drain_arbiter.sv | 118 +++++++++++
 tb/tb_bf16_drain_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_drain_arbiter.sv
// Round-robin drain arbiter sharing one int20->bf16 converter
// across accumulator lanes, two-stage pipeline with backpressure.

module int20_to_bf16 (
    input  logic [19:0] acc,
    output logic [15:0] bf16
);
    logic [19:0] mag;
    logic [19:0] norm;
    logic [4:0]  lead;

    always_comb begin
        mag  = acc[19] ? (~acc + 20'd1) : acc;
        lead = '0;
        for (int i = 0; i < 20; i++) begin
            if (mag[i]) lead = 5'(i);
        end
        // left-justify so the bits under the leading one land in [18:12]
        norm = mag << (5'd19 - lead);
        if (mag == '0) begin
            bf16 = '0;
        end else begin
            bf16 = {acc[19], 8'(lead) + 8'd103, norm[18:12]};
        end
    end
endmodule

module bf16_drain_arbiter #(
    parameter  int NUM_LANES = 4,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_LANES-1:0]    req_valid,
    input  logic [20*NUM_LANES-1:0] req_acc,
    output logic [NUM_LANES-1:0]    req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_bf16,
    output logic [LANE_W-1:0]       out_lane,
    output logic                    busy,
    output logic [15:0]             conv_count
);
    logic [19:0]          s1_acc;
    logic [LANE_W-1:0]    s1_lane;
    logic                 s1_valid;
    logic [LANE_W-1:0]    last_grant;
    logic [NUM_LANES-1:0] grant;
    logic [LANE_W-1:0]    gidx;
    logic                 found;
    logic                 out_adv;
    logic                 s1_free;
    logic                 hs;
    logic [15:0]          conv_bf16;
    int                   idx;

    assign out_adv = !out_valid | out_ready;
    assign s1_free = !s1_valid | out_adv;
    assign busy    = s1_valid | out_valid;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = (int'(last_grant) + 1 + k) % NUM_LANES;
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = LANE_W'(idx);
                found      = 1'b1;
            end
        end
    end

    // held low while reset is asserted so no handshake can be lost to it
    assign req_ready = grant & {NUM_LANES{s1_free & !rst}};
    assign hs        = |req_ready;

    int20_to_bf16 u_conv (
        .acc  (s1_acc),
        .bf16 (conv_bf16)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_acc     <= '0;
            s1_lane    <= '0;
            s1_valid   <= 1'b0;
            last_grant <= LANE_W'(NUM_LANES - 1);
            out_valid  <= 1'b0;
            out_bf16   <= '0;
            out_lane   <= '0;
            conv_count <= '0;
        end else begin
            if (s1_free) begin
                if (hs) begin
                    s1_acc     <= req_acc[int'(gidx)*20 +: 20];
                    s1_lane    <= gidx;
                    s1_valid   <= 1'b1;
                    last_grant <= gidx;
                end else begin
                    s1_valid <= 1'b0;
                end
            end
            if (out_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_bf16 <= conv_bf16;
                    out_lane <= s1_lane;
                end
            end
            if (out_valid && out_ready) begin
                conv_count <= conv_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_bf16_drain_arbiter.sv
// Self-checking bench for bf16_drain_arbiter: directed steps plus
// randomized traffic against a FIFO-level reference model.

module tb_bf16_drain_arbiter;
    localparam int L = 4;

    logic          clk;
    logic          rst;
    logic [L-1:0]  req_valid;
    logic [20*L-1:0] req_acc;
    logic [L-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_bf16;
    logic [1:0]    out_lane;
    logic          busy;
    logic [15:0]   conv_count;

    bf16_drain_arbiter #(.NUM_LANES(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_acc    (req_acc),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bf16   (out_bf16),
        .out_lane   (out_lane),
        .busy       (busy),
        .conv_count (conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lane;
        int acc;
        bit fresh;
    } item_t;

    item_t       q[$];
    int          seen[$];
    int          ptr;
    logic [15:0] cnt;
    int          g_lane;
    int          n_cmp;
    int          n_bad;

    function automatic logic [15:0] ref_bf16(int a);
        int m;
        int e;
        int mant;
        logic [7:0] ex;
        logic [6:0] mt;
        if (a == 0) return 16'h0000;
        m = (a < 0) ? -a : a;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e >= 7) mant = (m >> (e - 7)) & 127;
        else        mant = (m << (7 - e)) & 127;
        ex = 8'(e + 103);
        mt = 7'(mant);
        return {a < 0, ex, mt};
    endfunction

    function automatic int rand_acc();
        logic [31:0] r;
        r = $urandom;
        case (r[31:29])
            3'd0:    return 0;
            3'd1:    return -524288;
            3'd2:    return 1 << (r % 19);
            3'd3:    return -(1 << (r % 19));
            default: return int'($signed(r[19:0]));
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_acc(int l, int a);
        logic [31:0] au;
        au = a;
        req_acc[l*20 +: 20] = au[19:0];
    endtask

    task automatic model_reset();
        q.delete();
        ptr = 0;
        cnt = '0;
    endtask

    // one clock cycle: check outputs against the model, then advance it
    task automatic tick();
        int w;
        int l;
        bit ov;
        bit acc_ok;
        logic [L-1:0] exp_rdy;
        logic [19:0] a;
        item_t it;
        #1;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_count", conv_count, 0);
            g_lane = -1;
            @(posedge clk);
            @(negedge clk);
            return;
        end
        ov     = q.size() > 0 && !q[0].fresh;
        acc_ok = q.size() < 2 || (ov && out_ready);
        w = -1;
        for (int k = 0; k < L; k++) begin
            l = (ptr + k) % L;
            if (w < 0 && req_valid[l]) w = l;
        end
        exp_rdy = (acc_ok && w >= 0) ? L'(1 << w) : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("out_valid", out_valid, ov);
        chk("busy", busy, q.size() > 0);
        chk("conv_count", conv_count, cnt);
        if (ov) begin
            chk("out_bf16", out_bf16, ref_bf16(q[0].acc));
            chk("out_lane", out_lane, q[0].lane);
        end
        @(posedge clk);
        if (ov && out_ready) begin
            seen.push_back(q[0].lane);
            void'(q.pop_front());
            cnt++;
        end
        foreach (q[i]) q[i].fresh = 1'b0;
        g_lane = -1;
        if (exp_rdy != '0) begin
            a        = req_acc[w*20 +: 20];
            it.lane  = w;
            it.acc   = int'($signed(a));
            it.fresh = 1'b1;
            q.push_back(it);
            ptr    = (w + 1) % L;
            g_lane = w;
        end
        @(negedge clk);
    endtask

    int single_vals[5] = '{1, -1, 0, 256, -524288};
    logic [15:0] single_exp[5] = '{16'h3380, 16'hB380, 16'h0000,
                                   16'h3780, 16'hBD00};
    int lane0_acc;
    int iter;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        g_lane    = -1;
        rst       = 1'b1;
        req_valid = '0;
        req_acc   = '0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        tick();
        #1;
        chk("rst_bf16", out_bf16, 16'h0000);
        chk("rst_lane", out_lane, 0);
        rst = 1'b0;
        tick();

        // single lane, exact converter values, 2-cycle latency
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b0100;
            set_acc(2, single_vals[i]);
            tick();
            req_valid = '0;
            tick();
            chk("lat_valid", out_valid, 1);
            chk("exact_bf16", out_bf16, single_exp[i]);
            chk("exact_lane", out_lane, 2);
            tick();
        end
        chk("single_count", conv_count, 5);

        // randomized traffic with held requests
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom % 10) < 7;
            tick();
            if (g_lane >= 0) req_valid[g_lane] = 1'b0;
            for (int l = 0; l < L; l++) begin
                if (!req_valid[l] && $urandom % 2 == 1) begin
                    req_valid[l] = 1'b1;
                    set_acc(l, rand_acc());
                end
            end
        end

        // reset mid-stream
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_count", conv_count, 0);
        chk("mid_ready", req_ready, 0);
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // round-robin with all lanes valid
        out_ready = 1'b1;
        seen.delete();
        for (int c = 0; c < 8; c++) begin
            tick();
            if (g_lane >= 0) set_acc(g_lane, rand_acc());
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) tick();
        chk("rr_len", seen.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < seen.size()) chk("rr_lane", seen[i], i % L);
        end

        // sparse fairness, last grant was lane 3
        seen.delete();
        req_valid = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (g_lane >= 0) set_acc(g_lane, rand_acc());
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) tick();
        chk("sp_len", seen.size(), 8);
        foreach (seen[i]) chk("sp_lane", seen[i], (i % 2 == 1) ? 3 : 1);

        // backpressure: two results buffered, nothing else accepted
        seen.delete();
        for (int l = 0; l < L; l++) set_acc(l, rand_acc());
        lane0_acc = int'($signed(req_acc[19:0]));
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        #1;
        chk("bp_ready", req_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_bf16", out_bf16, ref_bf16(lane0_acc));
        chk("bp_lane", out_lane, 0);
        req_valid = 4'b1100;
        out_ready = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 4; c++) tick();
        chk("bp_len", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("bp_ord0", seen[0], 0);
            chk("bp_ord1", seen[1], 1);
        end

        // saturate until the counter wraps
        for (int l = 0; l < L; l++) set_acc(l, rand_acc());
        req_valid = 4'b1111;
        out_ready = 1'b1;
        iter = 0;
        while (cnt != 16'hFFFF && iter < 70000) begin
            tick();
            if (g_lane >= 0) set_acc(g_lane, rand_acc());
            iter++;
        end
        chk("wrap_ffff", conv_count, 16'hFFFF);
        tick();
        chk("wrap_zero", conv_count, 16'h0000);
        req_valid = '0;
        for (int c = 0; c < 3; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
